miter_stim_driver: RTL and testbench

Sequential stimulus-and-compare harness that drives a gold/gate pair of a small combinational partition, such as adder carry, with every input combination. It checks the two outputs bit-for-bit and counts mismatches. It is the driving end of the miter interface: the miter consumes primary inputs and compares primary outputs, and this block produces those inputs and sequences the comparison in simulation or on FPGA. Gold-side X bits are don't-care, as in the miter compare rule.

---
 rtl/miter_stim_driver.sv | 125 ++++++++++++
 tb/tb_miter_stim_driver.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/miter_stim_driver.sv
// Exhaustive stimulus generator and bit-for-bit comparator for a gold/gate pair.
// Walks every {pi_a, pi_b} combination, waits SETTLE cycles per vector, then checks the outputs.
module miter_stim_driver #(
    parameter int IN_W         = 1,
    parameter int OUT_W        = 1,
    parameter int SETTLE       = 1,
    parameter int STOP_ON_FAIL = 0,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    output logic [IN_W-1:0]  pi_a,
    output logic [IN_W-1:0]  pi_b,
    input  logic [OUT_W-1:0] po_gold,
    input  logic [OUT_W-1:0] po_gate,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_count,
    output logic             fail_valid,
    output logic [IN_W-1:0]  first_fail_a,
    output logic [IN_W-1:0]  first_fail_b
);

    localparam int VEC_W = 2 * IN_W;
    localparam int SET_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CHECK,
        S_DONE
    } state_t;

    state_t           state;
    logic [VEC_W-1:0] vec;
    logic [SET_W-1:0] settle_cnt;
    logic             captured;
    logic             mismatch;
    logic             fail_hit;
    logic             vec_last;

    assign pi_a     = vec[VEC_W-1:IN_W];
    assign pi_b     = vec[IN_W-1:0];
    assign vec_last = &vec;
    assign mismatch = |(po_gold ^ po_gate);

    // An unknown gold bit makes the reduction unknown, so the if falls through and the bit is skipped.
    always_comb begin
        fail_hit = 1'b0;
        if (mismatch) begin
            fail_hit = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            vec          <= '0;
            settle_cnt   <= '0;
            captured     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            fail_count   <= '0;
            fail_valid   <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
        end else begin
            fail_valid <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_SETTLE;
                        vec          <= '0;
                        settle_cnt   <= SET_W'(SETTLE - 1);
                        captured     <= 1'b0;
                        fail_count   <= '0;
                        first_fail_a <= '0;
                        first_fail_b <= '0;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        pass         <= 1'b0;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == '0) begin
                        state <= S_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - SET_W'(1);
                    end
                end
                S_CHECK: begin
                    if (fail_hit) begin
                        fail_valid <= 1'b1;
                        if (fail_count != '1) begin
                            fail_count <= fail_count + CNT_W'(1);
                        end
                        if (!captured) begin
                            captured     <= 1'b1;
                            first_fail_a <= vec[VEC_W-1:IN_W];
                            first_fail_b <= vec[IN_W-1:0];
                        end
                    end
                    // The last vector ends the run, so vec never wraps back to zero.
                    if (vec_last || (fail_hit && (STOP_ON_FAIL != 0))) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= !fail_hit && (fail_count == '0);
                    end else begin
                        state      <= S_SETTLE;
                        vec        <= vec + VEC_W'(1);
                        settle_cnt <= SET_W'(SETTLE - 1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miter_stim_driver.sv
// Directed bench for miter_stim_driver: four instances cover the pass, fail, early-stop,
// saturation, X-skip, wider-operand, restart and mid-run reset behaviours.
module tb_miter_stim_driver;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] start;
    int         checks = 0;
    int         errors = 0;
    int         mode0  = 0;

    always #5 clk = ~clk;

    // Instance 0: 1-bit AND, gate behaviour picked by mode0 (0 equal, 1 OR gate, 2 gold X on 11).
    logic       a0, b0, gold0, gate0, busy0, done0, pass0, fv0, ffa0, ffb0;
    logic [7:0] fc0;
    always_comb begin
        gold0 = a0 & b0;
        gate0 = a0 & b0;
        if (mode0 == 1) begin
            gate0 = a0 | b0;
        end else if (mode0 == 2 && a0 && b0) begin
            gold0 = 1'bx;
            gate0 = 1'b0;
        end
    end
    miter_stim_driver #(.IN_W(1), .OUT_W(1), .SETTLE(1), .STOP_ON_FAIL(0), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start[0]), .pi_a(a0), .pi_b(b0),
        .po_gold(gold0), .po_gate(gate0), .busy(busy0), .done(done0), .pass(pass0),
        .fail_count(fc0), .fail_valid(fv0), .first_fail_a(ffa0), .first_fail_b(ffb0));

    // Instance 1: stop on first failure, gate = a|b.
    logic       a1, b1, gold1, gate1, busy1, done1, pass1, fv1, ffa1, ffb1;
    logic [7:0] fc1;
    assign gold1 = a1 & b1;
    assign gate1 = a1 | b1;
    miter_stim_driver #(.IN_W(1), .OUT_W(1), .SETTLE(1), .STOP_ON_FAIL(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start[1]), .pi_a(a1), .pi_b(b1),
        .po_gold(gold1), .po_gate(gate1), .busy(busy1), .done(done1), .pass(pass1),
        .fail_count(fc1), .fail_valid(fv1), .first_fail_a(ffa1), .first_fail_b(ffb1));

    // Instance 2: 1-bit counter with an always-wrong gate.
    logic       a2, b2, gold2, gate2, busy2, done2, pass2, fv2, ffa2, ffb2;
    logic [0:0] fc2;
    assign gold2 = a2 & b2;
    assign gate2 = ~(a2 & b2);
    miter_stim_driver #(.IN_W(1), .OUT_W(1), .SETTLE(1), .STOP_ON_FAIL(0), .CNT_W(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start[2]), .pi_a(a2), .pi_b(b2),
        .po_gold(gold2), .po_gate(gate2), .busy(busy2), .done(done2), .pass(pass2),
        .fail_count(fc2), .fail_valid(fv2), .first_fail_a(ffa2), .first_fail_b(ffb2));

    // Instance 3: 2-bit adder with SETTLE=2, gate wrong only on a=2, b=3.
    logic [1:0] a3, b3, ffa3, ffb3;
    logic [2:0] gold3, gate3;
    logic       busy3, done3, pass3, fv3;
    logic [7:0] fc3;
    assign gold3 = {1'b0, a3} + {1'b0, b3};
    assign gate3 = gold3 ^ ((a3 == 2'd2 && b3 == 2'd3) ? 3'b100 : 3'b000);
    miter_stim_driver #(.IN_W(2), .OUT_W(3), .SETTLE(2), .STOP_ON_FAIL(0), .CNT_W(8)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .start(start[3]), .pi_a(a3), .pi_b(b3),
        .po_gold(gold3), .po_gate(gate3), .busy(busy3), .done(done3), .pass(pass3),
        .fail_count(fc3), .fail_valid(fv3), .first_fail_a(ffa3), .first_fail_b(ffb3));

    logic [3:0] done_v, busy_v, fv_v;
    assign done_v = {done3, done2, done1, done0};
    assign busy_v = {busy3, busy2, busy1, busy0};
    assign fv_v   = {fv3, fv2, fv1, fv0};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Pulses start, then counts busy samples and fail_valid pulses until done (bounded).
    task automatic applyStimulus(input int idx, input int glitch_at, output int busy_cycles, output int fv_pulses);
        busy_cycles = 0;
        fv_pulses   = 0;
        start[idx]  = 1'b1;
        tick();
        start[idx]  = 1'b0;
        checkOutput("done_drops_after_start", 32'(done_v[idx]), 32'd1 - 32'd1);
        for (int i = 0; i < 200; i++) begin
            if (fv_v[idx]) fv_pulses++;
            if (done_v[idx]) break;
            if (busy_v[idx]) busy_cycles++;
            start[idx] = (i == glitch_at);
            tick();
        end
        start[idx] = 1'b0;
        checkOutput("run_reaches_done", 32'(done_v[idx]), 32'd1);
    endtask

    int nb, nf;

    initial begin
        reset_n = 1'b0;
        start   = 4'b0000;
        tick();
        tick();
        reset_n = 1'b1;
        tick();

        checkOutput("rst_busy", 32'(busy0), 32'd0);
        checkOutput("rst_done", 32'(done0), 32'd0);
        checkOutput("rst_pass", 32'(pass0), 32'd0);
        checkOutput("rst_fail_count", 32'(fc0), 32'd0);
        checkOutput("rst_fail_valid", 32'(fv0), 32'd0);
        checkOutput("rst_pi", 32'({a0, b0}), 32'd0);
        checkOutput("rst_first_fail", 32'({ffa0, ffb0}), 32'd0);

        mode0 = 0;
        applyStimulus(0, -1, nb, nf);
        checkOutput("clean_busy_cycles", 32'(nb), 32'd8);
        checkOutput("clean_fv_pulses", 32'(nf), 32'd0);
        checkOutput("clean_pass", 32'(pass0), 32'd1);
        checkOutput("clean_fail_count", 32'(fc0), 32'd0);
        checkOutput("clean_busy_in_done", 32'(busy0), 32'd0);

        mode0 = 1;
        applyStimulus(0, -1, nb, nf);
        checkOutput("or_busy_cycles", 32'(nb), 32'd8);
        checkOutput("or_fv_pulses", 32'(nf), 32'd2);
        checkOutput("or_fail_count", 32'(fc0), 32'd2);
        checkOutput("or_first_fail", 32'({ffa0, ffb0}), 32'b01);
        checkOutput("or_pass", 32'(pass0), 32'd0);
        checkOutput("or_pi_held", 32'({a0, b0}), 32'b11);

        mode0 = 2;
        applyStimulus(0, -1, nb, nf);
        checkOutput("xskip_fail_count", 32'(fc0), 32'd0);
        checkOutput("xskip_pass", 32'(pass0), 32'd1);

        mode0 = 0;
        applyStimulus(0, 3, nb, nf);
        checkOutput("start_ignored_busy_cycles", 32'(nb), 32'd8);
        checkOutput("start_ignored_pi", 32'({a0, b0}), 32'b11);

        applyStimulus(1, -1, nb, nf);
        checkOutput("stop_busy_cycles", 32'(nb), 32'd4);
        checkOutput("stop_fv_pulses", 32'(nf), 32'd1);
        checkOutput("stop_fail_count", 32'(fc1), 32'd1);
        checkOutput("stop_pi_held", 32'({a1, b1}), 32'b01);
        checkOutput("stop_first_fail", 32'({ffa1, ffb1}), 32'b01);
        checkOutput("stop_pass", 32'(pass1), 32'd0);

        applyStimulus(2, -1, nb, nf);
        checkOutput("sat_busy_cycles", 32'(nb), 32'd8);
        checkOutput("sat_fv_pulses", 32'(nf), 32'd4);
        checkOutput("sat_fail_count", 32'(fc2), 32'd1);
        checkOutput("sat_first_fail", 32'({ffa2, ffb2}), 32'b00);
        checkOutput("sat_pass", 32'(pass2), 32'd0);

        applyStimulus(3, -1, nb, nf);
        checkOutput("wide_busy_cycles", 32'(nb), 32'd48);
        checkOutput("wide_fv_pulses", 32'(nf), 32'd1);
        checkOutput("wide_fail_count", 32'(fc3), 32'd1);
        checkOutput("wide_first_fail", 32'({ffa3, ffb3}), 32'b1011);
        checkOutput("wide_pi_held", 32'({a3, b3}), 32'b1111);
        checkOutput("wide_pass", 32'(pass3), 32'd0);

        // Mid-run reset: advance to vector 2, then pull reset_n low for one edge.
        mode0    = 1;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checkOutput("midrun_vec2", 32'({a0, b0}), 32'b10);
        checkOutput("midrun_fail_count", 32'(fc0), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checkOutput("midrst_busy", 32'(busy0), 32'd0);
        checkOutput("midrst_pi", 32'({a0, b0}), 32'd0);
        checkOutput("midrst_fail_count", 32'(fc0), 32'd0);
        checkOutput("midrst_first_fail", 32'({ffa0, ffb0}), 32'd0);
        checkOutput("midrst_done_pass", 32'({done0, pass0}), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        checkOutput("midrst_stays_idle", 32'({busy0, done0, a0, b0}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
